stream_packet_merger: RTL

STREAM_PACKET_MERGER -- requirements
Module: stream_packet_merger

---
 rtl/stream_packet_merger_if.sv | 24 ++
 rtl/stream_packet_merger.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/stream_packet_merger_if.sv
// Stream bundle for stream_packet_merger: NUM_INPUTS packed input streams plus one merged output stream.
// slave is the merger's view of the bundle; master is the view of whoever feeds and drains it.
interface stream_packet_merger_if #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_INPUTS-1:0]            s_axis_tvalid;
  logic [NUM_INPUTS-1:0]            s_axis_tlast;
  logic [NUM_INPUTS-1:0]            s_axis_tready;
  logic [DATA_WIDTH-1:0]            m_axis_tdata;
  logic                             m_axis_tvalid;
  logic                             m_axis_tlast;
  logic                             m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/stream_packet_merger.sv
// Packet-atomic round-robin merger: one FIFO per input, a lock-per-packet arbiter, one output register.
// Define STREAM_MERGER_TID_EN to add m_axis_tid (source channel of the beat in the output register).
module stream_packet_merger_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr, r_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (push) r_wr <= r_wr + 1'b1;
      if (pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr[AW-1:0]] <= din;
  end

  assign dout  = r_mem[r_rd[AW-1:0]];
  assign empty = (r_wr == r_rd);
  assign full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
endmodule

module stream_packet_merger #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  localparam int ID_WIDTH   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  stream_packet_merger_if.slave axis,
  input  logic [NUM_INPUTS-1:0] enable_mask,
  output logic [NUM_INPUTS-1:0] fifo_empty,
  output logic [ID_WIDTH-1:0]   grant_id,
  output logic                  busy
`ifdef STREAM_MERGER_TID_EN
  ,
  output logic [ID_WIDTH-1:0]   m_axis_tid
`endif
);
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                r_state, w_state_nxt;
  logic [ID_WIDTH-1:0]   r_grant, r_last_grant, w_sel;
  logic                  w_hit, w_pop;
  logic [NUM_INPUTS-1:0] w_empty, w_full, w_push, w_pop_vec;
  logic [DATA_WIDTH:0]   w_dout [NUM_INPUTS];
  logic [DATA_WIDTH:0]   w_cur;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_valid, r_m_last;

  // Hold tready low while reset is asserted so nothing is accepted into a clearing FIFO.
  assign axis.s_axis_tready = ap_rst_n ? ~w_full : '0;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_ch
    assign w_push[g]    = axis.s_axis_tvalid[g] && axis.s_axis_tready[g];
    assign w_pop_vec[g] = w_pop && (r_grant == ID_WIDTH'(g));
    stream_packet_merger_fifo #(.W(DATA_WIDTH+1), .DEPTH(FIFO_DEPTH), .AW(ADDR_WIDTH)) u_fifo (
      .clk   (ap_clk),
      .rst_n (ap_rst_n),
      .push  (w_push[g]),
      .din   ({axis.s_axis_tlast[g], axis.s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH]}),
      .pop   (w_pop_vec[g]),
      .dout  (w_dout[g]),
      .empty (w_empty[g]),
      .full  (w_full[g])
    );
  end

  // Round-robin search starting just past the last completed grant.
  always_comb begin
    logic [ID_WIDTH-1:0] idx;
    w_hit = 1'b0;
    w_sel = r_last_grant;
    idx   = '0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      idx = ID_WIDTH'((int'(r_last_grant) + k) % NUM_INPUTS);
      if (!w_hit && !w_empty[idx] && enable_mask[idx]) begin
        w_hit = 1'b1;
        w_sel = idx;
      end
    end
  end

  assign w_cur = w_dout[r_grant];
  assign w_pop = (r_state == LOCKED) && !w_empty[r_grant] &&
                 (!r_m_valid || axis.m_axis_tready);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_hit) w_state_nxt = LOCKED;
      LOCKED:  if (w_pop && w_cur[DATA_WIDTH]) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_grant      <= '0;
      r_last_grant <= ID_WIDTH'(NUM_INPUTS - 1);
    end else begin
      if (r_state == IDLE && w_hit) r_grant <= w_sel;
      if (r_state == LOCKED && w_pop && w_cur[DATA_WIDTH]) r_last_grant <= r_grant;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_data  <= '0;
    end else if (w_pop) begin
      r_m_valid <= 1'b1;
      r_m_last  <= w_cur[DATA_WIDTH];
      r_m_data  <= w_cur[DATA_WIDTH-1:0];
    end else if (axis.m_axis_tready) begin
      r_m_valid <= 1'b0;
    end
  end

`ifdef STREAM_MERGER_TID_EN
  logic [ID_WIDTH-1:0] r_m_tid;
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)  r_m_tid <= '0;
    else if (w_pop) r_m_tid <= r_grant;
  end
  assign m_axis_tid = r_m_tid;
`endif

  assign axis.m_axis_tdata  = r_m_data;
  assign axis.m_axis_tvalid = r_m_valid;
  assign axis.m_axis_tlast  = r_m_last;
  assign fifo_empty         = w_empty;
  assign grant_id           = r_grant;
  assign busy               = (r_state == LOCKED);
endmodule
